// File: rtl/enc_pkg.sv
// Shared definitions for the ENCRYPTION custom-instruction responder.
//   OPC_ENCRYPTION : major opcode claimed by this block
//   F3_*           : funct3 sub-operations (LDKEY / ENC / DEC)
//   enc_state_t    : responder FSM states
//   rotl16         : 16-bit rotate-left helper used by the round function
package enc_pkg;

  localparam logic [6:0] OPC_ENCRYPTION = 7'b0001011;

  localparam logic [2:0] F3_LDKEY = 3'b000;
  localparam logic [2:0] F3_ENC   = 3'b001;
  localparam logic [2:0] F3_DEC   = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } enc_state_t;

  function automatic logic [15:0] rotl16(input logic [15:0] x, input logic [3:0] n);
    return (x << n) | (x >> (5'd16 - {1'b0, n}));
  endfunction

endpackage

// File: rtl/enc_round.sv
// Combinational single Feistel round, shared by the ENC and DEC paths.
//   l, r   : current half-words
//   k      : round key
//   dec    : 0 = encrypt round, 1 = decrypt (inverse) round
//   l_nxt, r_nxt : half-words after the round
module enc_round
  import enc_pkg::*;
(
  input  logic [15:0] l,
  input  logic [15:0] r,
  input  logic [15:0] k,
  input  logic        dec,
  output logic [15:0] l_nxt,
  output logic [15:0] r_nxt
);

  logic [15:0] x;
  logic [15:0] f;

  // One F() instance serves both directions: ENC mixes R into L, DEC mixes L into R.
  always_comb begin
    x = dec ? l : r;
    f = (rotl16(x, 4'd3) + k) ^ (x >> 5);
    if (dec) begin
      l_nxt = r ^ f;
      r_nxt = l;
    end else begin
      l_nxt = r;
      r_nxt = l ^ f;
    end
  end

endmodule

// File: rtl/enc_cmd_responder.sv
// Responder for the ENCRYPTION custom instruction.
//   clk, rst        : clock, async active-high reset
//   flush           : aborts any in-flight command, no response
//   cmd_*           : command from decode (valid/ready handshake)
//   rsp_*           : single response to writeback (valid/ready handshake)
//   busy            : FSM not idle
// LDKEY loads the key, ENC/DEC run ROUNDS Feistel rounds one per cycle.
module enc_cmd_responder
  import enc_pkg::*;
#(
  parameter int unsigned ROUNDS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [6:0]  cmd_op,
  input  logic [2:0]  cmd_funct3,
  input  logic [31:0] cmd_rs1_data,
  input  logic [4:0]  cmd_rd,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [4:0]  rsp_rd,
  output logic        rsp_wen,
  output logic        rsp_err,
  output logic        busy
);

  localparam logic [3:0] LAST_IDX = 4'(ROUNDS - 1);

  enc_state_t  state;
  logic [31:0] key;
  logic [15:0] l_q;
  logic [15:0] r_q;
  logic [3:0]  idx;
  logic [2:0]  f3_q;
  logic [4:0]  rd_q;

  logic        dec_mode;
  logic        accept;
  logic        last_round;
  logic [15:0] round_key;
  logic [15:0] l_nxt;
  logic [15:0] r_nxt;

  assign dec_mode   = (f3_q == F3_DEC);
  assign accept     = (state == ST_IDLE) && cmd_valid && (cmd_op == OPC_ENCRYPTION) && !flush;
  assign last_round = dec_mode ? (idx == 4'd0) : (idx == LAST_IDX);
  assign round_key  = (idx[0] ? key[31:16] : key[15:0]) ^ {12'b0, idx};

  assign cmd_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);

  enc_round u_round (
    .l     (l_q),
    .r     (r_q),
    .k     (round_key),
    .dec   (dec_mode),
    .l_nxt (l_nxt),
    .r_nxt (r_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      key       <= '0;
      l_q       <= '0;
      r_q       <= '0;
      idx       <= '0;
      f3_q      <= '0;
      rd_q      <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_rd    <= '0;
      rsp_wen   <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            rd_q <= cmd_rd;
            f3_q <= cmd_funct3;
            case (cmd_funct3)
              F3_ENC, F3_DEC: begin
                l_q   <= cmd_rs1_data[31:16];
                r_q   <= cmd_rs1_data[15:0];
                idx   <= (cmd_funct3 == F3_DEC) ? LAST_IDX : 4'd0;
                state <= ST_RUN;
              end
              default: begin
                // LDKEY and illegal funct3 answer immediately with no GPR write.
                if (cmd_funct3 == F3_LDKEY) begin
                  key <= cmd_rs1_data;
                end
                rsp_valid <= 1'b1;
                rsp_data  <= '0;
                rsp_rd    <= cmd_rd;
                rsp_wen   <= 1'b0;
                rsp_err   <= (cmd_funct3 != F3_LDKEY);
                state     <= ST_DONE;
              end
            endcase
          end
        end

        ST_RUN: begin
          if (flush) begin
            state <= ST_IDLE;
          end else begin
            l_q <= l_nxt;
            r_q <= r_nxt;
            if (last_round) begin
              rsp_valid <= 1'b1;
              rsp_data  <= {l_nxt, r_nxt};
              rsp_rd    <= rd_q;
              rsp_wen   <= 1'b1;
              rsp_err   <= 1'b0;
              state     <= ST_DONE;
            end else begin
              idx <= dec_mode ? (idx - 4'd1) : (idx + 4'd1);
            end
          end
        end

        ST_DONE: begin
          if (flush || rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_enc_cmd_responder.sv
// Self-checking bench for enc_cmd_responder: a ROUNDS=1 and a ROUNDS=8
// instance (index 0 and 1) driven from a shared vector table plus
// directed sequences for stall, flush and reset corner cases.
module tb_enc_cmd_responder;
  import enc_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        flush        [2];
  logic        cmd_valid    [2];
  logic        cmd_ready    [2];
  logic [6:0]  cmd_op       [2];
  logic [2:0]  cmd_funct3   [2];
  logic [31:0] cmd_rs1_data [2];
  logic [4:0]  cmd_rd       [2];
  logic        rsp_valid    [2];
  logic        rsp_ready    [2];
  logic [31:0] rsp_data     [2];
  logic [4:0]  rsp_rd       [2];
  logic        rsp_wen      [2];
  logic        rsp_err      [2];
  logic        busy         [2];

  enc_cmd_responder #(.ROUNDS(1)) u_r1 (
    .clk(clk), .rst(rst), .flush(flush[0]), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
    .cmd_op(cmd_op[0]), .cmd_funct3(cmd_funct3[0]), .cmd_rs1_data(cmd_rs1_data[0]), .cmd_rd(cmd_rd[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_data(rsp_data[0]), .rsp_rd(rsp_rd[0]),
    .rsp_wen(rsp_wen[0]), .rsp_err(rsp_err[0]), .busy(busy[0])
  );

  enc_cmd_responder #(.ROUNDS(8)) u_r8 (
    .clk(clk), .rst(rst), .flush(flush[1]), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
    .cmd_op(cmd_op[1]), .cmd_funct3(cmd_funct3[1]), .cmd_rs1_data(cmd_rs1_data[1]), .cmd_rd(cmd_rd[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_data(rsp_data[1]), .rsp_rd(rsp_rd[1]),
    .rsp_wen(rsp_wen[1]), .rsp_err(rsp_err[1]), .busy(busy[1])
  );

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int          d;
    logic [2:0]  f3;
    logic [31:0] rs1;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        wen;
    logic        err;
    int          lat;   // expected edges from accept to rsp_valid, -1 = not checked
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(int d, logic [2:0] f3, logic [31:0] rs1, logic [4:0] rd,
                              logic [31:0] data, logic wen, logic err, int lat);
    vec_t v;
    v.d = d; v.f3 = f3; v.rs1 = rs1; v.rd = rd;
    v.data = data; v.wen = wen; v.err = err; v.lat = lat;
    return v;
  endfunction

  // Reference cipher written straight from the algorithm description.
  function automatic logic [15:0] fmix(logic [15:0] x, logic [15:0] k);
    logic [15:0] rot;
    rot = {x[12:0], x[15:13]};
    return (rot + k) ^ {5'b0, x[15:5]};
  endfunction

  function automatic logic [31:0] model(logic [31:0] x, logic [31:0] key, int rounds, bit dec);
    logic [15:0] l, r, t, k;
    int idx;
    l = x[31:16];
    r = x[15:0];
    for (int n = 0; n < rounds; n++) begin
      idx = dec ? (rounds - 1 - n) : n;
      k = ((idx % 2) != 0 ? key[31:16] : key[15:0]) ^ 16'(idx);
      if (!dec) begin
        t = r;
        r = l ^ fmix(r, k);
        l = t;
      end else begin
        t = l;
        l = r ^ fmix(l, k);
        r = t;
      end
    end
    return {l, r};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Wait for cmd_ready, present one command for the accept edge, return at the following negedge.
  task automatic start(input int d, input logic [2:0] f3, input logic [31:0] rs1, input logic [4:0] rd);
    int w;
    w = 0;
    while (cmd_ready[d] !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("ready_wait", cmd_ready[d], 1);
    cmd_valid[d]    = 1'b1;
    cmd_op[d]       = OPC_ENCRYPTION;
    cmd_funct3[d]   = f3;
    cmd_rs1_data[d] = rs1;
    cmd_rd[d]       = rd;
    @(posedge clk);
    @(negedge clk);
    cmd_valid[d] = 1'b0;
  endtask

  task automatic issue(input int d, input logic [2:0] f3, input logic [31:0] rs1,
                       input logic [4:0] rd, output int lat);
    start(d, f3, rs1, rd);
    lat = 0;
    while (rsp_valid[d] !== 1'b1 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic handshake(input int d, input string name);
    rsp_ready[d] = 1'b1;
    @(negedge clk);
    rsp_ready[d] = 1'b0;
    check({name, "_rsp_clr"}, rsp_valid[d], 0);
    check({name, "_ready_back"}, cmd_ready[d], 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    logic [31:0] e_dead, e_zero, e_stall, exp_d;
    bit          seen;
    string       nm;

    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      flush[d] = 1'b0; cmd_valid[d] = 1'b0; cmd_op[d] = OPC_ENCRYPTION;
      cmd_funct3[d] = '0; cmd_rs1_data[d] = '0; cmd_rd[d] = '0; rsp_ready[d] = 1'b0;
    end

    e_dead = model(32'hDEADBEEF, 32'hA5A55A5A, 8, 1'b0);
    e_zero = model(32'h00000000, 32'hA5A55A5A, 8, 1'b0);

    // ROUNDS=1 instance
    vecs.push_back(mk(0, F3_LDKEY, 32'h00000000, 5'd1,  32'h00000000, 1'b0, 1'b0, -1));
    vecs.push_back(mk(0, F3_ENC,   32'h12340000, 5'd5,  32'h00001234, 1'b1, 1'b0, 1));
    vecs.push_back(mk(0, F3_ENC,   32'h00000001, 5'd7,  32'h00010008, 1'b1, 1'b0, 1));
    vecs.push_back(mk(0, F3_DEC,   32'h00010008, 5'd9,  32'h00000001, 1'b1, 1'b0, 1));
    vecs.push_back(mk(0, 3'b111,   32'hFFFFFFFF, 5'd3,  32'h00000000, 1'b0, 1'b1, -1));
    vecs.push_back(mk(0, F3_ENC,   32'h00000001, 5'd4,  32'h00010008, 1'b1, 1'b0, 1));
    vecs.push_back(mk(0, F3_LDKEY, 32'h00000002, 5'd6,  32'h00000000, 1'b0, 1'b0, -1));
    vecs.push_back(mk(0, F3_ENC,   32'h00000001, 5'd8,  32'h0001000A, 1'b1, 1'b0, 1));
    vecs.push_back(mk(0, F3_ENC,   32'h00FF0020, 5'd13, 32'h002001FC, 1'b1, 1'b0, 1));
    vecs.push_back(mk(0, F3_DEC,   32'h002001FC, 5'd14, 32'h00FF0020, 1'b1, 1'b0, 1));
    // ROUNDS=8 instance
    vecs.push_back(mk(1, F3_LDKEY, 32'hA5A55A5A, 5'd2,  32'h00000000, 1'b0, 1'b0, -1));
    vecs.push_back(mk(1, F3_ENC,   32'hDEADBEEF, 5'd10, e_dead,       1'b1, 1'b0, 8));
    vecs.push_back(mk(1, F3_DEC,   e_dead,       5'd11, 32'hDEADBEEF, 1'b1, 1'b0, 8));
    vecs.push_back(mk(1, 3'b011,   32'h00001111, 5'd31, 32'h00000000, 1'b0, 1'b1, -1));
    vecs.push_back(mk(1, F3_ENC,   32'h00000000, 5'd15, e_zero,       1'b1, 1'b0, 8));

    // Reset state
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst%0d_outs", d),
            {rsp_valid[d], rsp_data[d], rsp_rd[d], rsp_wen[d], rsp_err[d], busy[d]}, 0);
      check($sformatf("rst%0d_ready", d), cmd_ready[d], 1);
    end
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[n]) begin
      issue(vecs[n].d, vecs[n].f3, vecs[n].rs1, vecs[n].rd, lat);
      nm = $sformatf("v%0d", n);
      check({nm, "_valid"}, rsp_valid[vecs[n].d], 1);
      check({nm, "_data"},  rsp_data[vecs[n].d], vecs[n].data);
      check({nm, "_rd"},    rsp_rd[vecs[n].d],   vecs[n].rd);
      check({nm, "_wen"},   rsp_wen[vecs[n].d],  vecs[n].wen);
      check({nm, "_err"},   rsp_err[vecs[n].d],  vecs[n].err);
      if (vecs[n].lat >= 0) check({nm, "_lat"}, lat, vecs[n].lat);
      handshake(vecs[n].d, nm);
    end

    // Stall in DONE with a competing command presented; it must not be taken.
    e_stall = model(32'h0BADF00D, 32'hA5A55A5A, 8, 1'b0);
    issue(1, F3_ENC, 32'h0BADF00D, 5'd12, lat);
    check("stall_lat", lat, 8);
    for (int c = 0; c < 5; c++) begin
      cmd_valid[1] = 1'b1; cmd_funct3[1] = F3_LDKEY; cmd_rs1_data[1] = 32'hFFFFFFFF;
      @(negedge clk);
      check($sformatf("stall%0d_valid", c), rsp_valid[1], 1);
      check($sformatf("stall%0d_data", c), {rsp_data[1], rsp_rd[1], rsp_wen[1]}, {e_stall, 5'd12, 1'b1});
      check($sformatf("stall%0d_ready", c), cmd_ready[1], 0);
    end
    rsp_ready[1] = 1'b1;
    @(negedge clk);
    rsp_ready[1] = 1'b0;
    cmd_valid[1] = 1'b0;
    check("hs_no_same_cycle_accept", busy[1], 0);
    check("hs_rsp_clr", rsp_valid[1], 0);

    // Key must still be A5A55A5A.
    issue(1, F3_ENC, 32'h00000001, 5'd16, lat);
    check("key_kept_data", rsp_data[1], model(32'h00000001, 32'hA5A55A5A, 8, 1'b0));
    handshake(1, "key_kept");

    // Flush during round 3 of ENC.
    start(1, F3_ENC, 32'h13572468, 5'd17);
    repeat (2) @(negedge clk);
    flush[1] = 1'b1;
    @(negedge clk);
    flush[1] = 1'b0;
    check("flush_idle", busy[1], 0);
    check("flush_no_rsp", rsp_valid[1], 0);
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      seen |= rsp_valid[1];
    end
    check("flush_never_rsp", seen, 0);

    // Flush in IDLE blocks accept.
    cmd_valid[1] = 1'b1; cmd_funct3[1] = F3_ENC; flush[1] = 1'b1;
    @(negedge clk);
    check("flush_idle_block", busy[1], 0);
    cmd_valid[1] = 1'b0; flush[1] = 1'b0;

    // Foreign opcode ignored.
    cmd_valid[1] = 1'b1; cmd_op[1] = 7'b0110011; cmd_funct3[1] = F3_ENC;
    @(negedge clk);
    check("foreign_op_busy", busy[1], 0);
    check("foreign_op_ready", cmd_ready[1], 1);
    cmd_valid[1] = 1'b0; cmd_op[1] = OPC_ENCRYPTION;

    // Async reset mid-RUN: outputs clear without waiting for a clock edge.
    start(1, F3_ENC, 32'hCAFEBABE, 5'd18);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_outs",
          {rsp_valid[1], rsp_data[1], rsp_rd[1], rsp_wen[1], rsp_err[1], busy[1]}, 0);
    check("arst_ready", cmd_ready[1], 1);
    check("arst_outs_r1", {rsp_data[0], rsp_rd[0], rsp_wen[0]}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("arst_no_rsp", {rsp_valid[1], busy[1]}, 0);

    // Key returned to zero in both instances.
    issue(1, F3_ENC, 32'h00000001, 5'd19, lat);
    exp_d = model(32'h00000001, 32'h00000000, 8, 1'b0);
    check("arst_key0_r8", rsp_data[1], exp_d);
    handshake(1, "arst_key0_r8");
    issue(0, F3_ENC, 32'h00FF0020, 5'd20, lat);
    check("arst_key0_r1", rsp_data[0], 32'h002001FE);
    handshake(0, "arst_key0_r1");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
